// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: default data width, FIFO depth
// and the occupancy/pointer width helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W         = 8;
  localparam int unsigned UART_FIFO_DEPTH_DEF = 16;
  localparam int unsigned UART_FIFO_CNT_W_DEF = $clog2(UART_FIFO_DEPTH_DEF) + 1;

  // Occupancy needs one extra bit so a full FIFO (DEPTH) is representable.
  function automatic int unsigned uart_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read, contents never reset.
module uart_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO fed by a UART byte-valid level.
// Define UART_RX_FIFO_OVF_CNT_EN to add the saturating o_Ovf_Count output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = UART_FIFO_DEPTH_DEF,
  parameter int unsigned WIDTH = UART_DATA_W
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_n,
  input  logic                     i_RX_DV,
  input  logic [WIDTH-1:0]         i_RX_Byte,
  output logic [WIDTH-1:0]         o_Data,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic [$clog2(DEPTH):0]   o_Count,
  input  logic                     i_Clear_Ovf,
  output logic                     o_Overflow
`ifdef UART_RX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]               o_Ovf_Count
`endif
);

  localparam int unsigned CW = uart_cnt_w(DEPTH);
  localparam int unsigned AW = CW - 1;

  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             dv_prev_q, dv_prev_d;
  logic             ovf_q, ovf_d;
  logic             capture, empty, full, pop, push, drop;
  logic [WIDTH-1:0] rd_data;

  // A pop frees the full slot in the same cycle, so capture-while-full is
  // only a drop when nothing is being consumed.
  always_comb begin
    capture   = i_RX_DV & ~dv_prev_q;
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[CW-1] != rd_ptr_q[CW-1]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = ~empty & i_Ready;
    push      = capture & (~full | pop);
    drop      = capture & full & ~pop;
    dv_prev_d = i_RX_DV;
    wr_ptr_d  = push ? wr_ptr_q + CW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + CW'(1) : rd_ptr_q;
    ovf_d     = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (i_Clear_Ovf) begin
      ovf_d = 1'b0;
    end
  end

  // dv_prev resets high so a level already asserted at release is ignored.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      dv_prev_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      dv_prev_q <= dv_prev_d;
      ovf_q     <= ovf_d;
    end
  end

  uart_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (i_Clock),
    .wr_en   (push),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (i_RX_Byte),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  assign o_Valid    = ~empty;
  assign o_Data     = empty ? '0 : rd_data;
  assign o_Count    = wr_ptr_q - rd_ptr_q;
  assign o_Overflow = ovf_q;

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      if (ovf_cnt_q != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end else if (i_Clear_Ovf) begin
      ovf_cnt_d = '0;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign o_Ovf_Count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned D = 16;
  localparam int unsigned W = 8;

  logic         clk;
  logic         i_Rst_n;
  logic         i_RX_DV;
  logic [W-1:0] i_RX_Byte;
  logic [W-1:0] o_Data;
  logic         o_Valid;
  logic         i_Ready;
  logic [4:0]   o_Count;
  logic         i_Clear_Ovf;
  logic         o_Overflow;
`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0]   o_Ovf_Count;
`endif

  uart_rx_fifo #(
    .DEPTH (D),
    .WIDTH (W)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (i_Rst_n),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .o_Data      (o_Data),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_Count     (o_Count),
    .i_Clear_Ovf (i_Clear_Ovf),
    .o_Overflow  (o_Overflow)
`ifdef UART_RX_FIFO_OVF_CNT_EN
    ,
    .o_Ovf_Count (o_Ovf_Count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Reference model: a byte queue plus the edge-detect and sticky flag state.
  logic [W-1:0] mq[$];
  logic         m_prev;
  logic         m_ovf;
  logic [7:0]   m_ocnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_prev = 1'b1;
    m_ovf  = 1'b0;
    m_ocnt = 8'd0;
  endtask

  task automatic model_edge();
    bit pop, cap, dropped;
    pop     = (mq.size() != 0) && i_Ready;
    cap     = i_RX_DV && !m_prev;
    dropped = 1'b0;
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (mq.size() < D) mq.push_back(i_RX_Byte);
      else dropped = 1'b1;
    end
    if (dropped) begin
      m_ovf = 1'b1;
      if (m_ocnt != 8'd255) m_ocnt = m_ocnt + 8'd1;
    end else if (i_Clear_Ovf) begin
      m_ovf  = 1'b0;
      m_ocnt = 8'd0;
    end
    m_prev = i_RX_DV;
  endtask

  task automatic cmp_model(input string tag);
    logic [W-1:0] exp_data;
    exp_data = (mq.size() != 0) ? mq[0] : '0;
    chk({tag, ".count"}, 32'(o_Count), 32'(mq.size()));
    chk({tag, ".valid"}, 32'(o_Valid), 32'(mq.size() != 0));
    chk({tag, ".data"},  32'(o_Data),  32'(exp_data));
    chk({tag, ".ovf"},   32'(o_Overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_OVF_CNT_EN
    chk({tag, ".ovf_cnt"}, 32'(o_Ovf_Count), 32'(m_ocnt));
`endif
  endtask

  task automatic step(input logic dv, input logic [W-1:0] b, input logic rdy,
                      input logic clr, input string tag);
    i_RX_DV     = dv;
    i_RX_Byte   = b;
    i_Ready     = rdy;
    i_Clear_Ovf = clr;
    @(posedge clk);
    model_edge();
    #1;
    cmp_model(tag);
  endtask

  task automatic do_reset(input logic dv_level);
    i_RX_DV     = dv_level;
    i_RX_Byte   = '0;
    i_Ready     = 1'b0;
    i_Clear_Ovf = 1'b0;
    i_Rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 i_Rst_n = 1'b1;
  endtask

  typedef struct {
    logic         dv;
    logic [W-1:0] b;
    logic         rdy;
    logic         clr;
    int unsigned  exp_cnt;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_ovf;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [W-1:0] rb;
    logic         dv;
    int unsigned  thr;

    // Idle first: dv_prev comes out of reset high and must see a low.
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h41, 1'b0};
    tbl[3]  = '{1'b1, 8'h42, 1'b0, 1'b0, 2, 1'b1, 8'h41, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b1, 8'h41, 1'b0};
    tbl[5]  = '{1'b1, 8'h43, 1'b0, 1'b0, 3, 1'b1, 8'h41, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3, 1'b1, 8'h41, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h42, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h43, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b1, 8'h55, 1'b0};
    tbl[12] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b1, 8'h55, 1'b0};
    tbl[13] = '{1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b1, 8'h55, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b1, 8'h55, 1'b0};
    tbl[15] = '{1'b1, 8'h66, 1'b1, 1'b0, 1, 1'b1, 8'h66, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

    i_Rst_n = 1'b0;
    do_reset(1'b0);
    #1;
    chk("rst.count", 32'(o_Count), 0);
    chk("rst.valid", 32'(o_Valid), 0);
    chk("rst.data",  32'(o_Data), 0);
    chk("rst.ovf",   32'(o_Overflow), 0);

    foreach (tbl[i]) begin
      step(tbl[i].dv, tbl[i].b, tbl[i].rdy, tbl[i].clr, "tbl_model");
      chk($sformatf("tbl%0d.count", i), 32'(o_Count), tbl[i].exp_cnt);
      chk($sformatf("tbl%0d.valid", i), 32'(o_Valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d.data", i),  32'(o_Data),  32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d.ovf", i),   32'(o_Overflow), 32'(tbl[i].exp_ovf));
    end

    // Fill to DEPTH, then overflow with 0xFF.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, "fill");
      step(1'b0, 8'h00, 1'b0, 1'b0, "fill");
    end
    chk("full.count", 32'(o_Count), 16);
    step(1'b1, 8'hFF, 1'b0, 1'b0, "ovf");
    chk("ovf.flag",  32'(o_Overflow), 1);
    chk("ovf.count", 32'(o_Count), 16);
    chk("ovf.head",  32'(o_Data), 32'h10);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    chk("ovf.cnt", 32'(o_Ovf_Count), 1);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b0, "ovf");

    // Clear colliding with a new drop: set wins; then clear alone.
    step(1'b1, 8'hEE, 1'b0, 1'b1, "clr_coll");
    chk("clr_coll.flag", 32'(o_Overflow), 1);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    chk("clr_coll.cnt", 32'(o_Ovf_Count), 2);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b1, "clr_alone");
    chk("clr_alone.flag", 32'(o_Overflow), 0);

    // Full with a capture coinciding with a pop: no overflow, byte kept last.
    step(1'b1, 8'hA5, 1'b1, 1'b0, "full_pushpop");
    chk("full_pushpop.count", 32'(o_Count), 16);
    chk("full_pushpop.ovf",   32'(o_Overflow), 0);
    chk("full_pushpop.head",  32'(o_Data), 32'h11);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    chk("drain.last_data",  32'(o_Data), 32'hA5);
    chk("drain.last_count", 32'(o_Count), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    chk("drain.empty", 32'(o_Valid), 0);

    // Asynchronous reset mid-stream with five bytes queued.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, "queue5");
      step(1'b0, 8'h00, 1'b0, 1'b0, "queue5");
    end
    chk("queue5.count", 32'(o_Count), 5);
    #2 i_Rst_n = 1'b0;
    #1;
    chk("async_rst.count", 32'(o_Count), 0);
    chk("async_rst.valid", 32'(o_Valid), 0);
    chk("async_rst.data",  32'(o_Data), 0);
    chk("async_rst.ovf",   32'(o_Overflow), 0);

    // DV held high across reset release must not capture.
    do_reset(1'b1);
    for (int i = 0; i < 217; i++) begin
      step(1'b1, 8'h77, 1'b0, 1'b0, "dv_held");
      if (i == 216) begin
        chk("dv_held.count", 32'(o_Count), 0);
        chk("dv_held.valid", 32'(o_Valid), 0);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, "dv_held");

    // Randomized traffic with phased consumer rates to hit full and empty.
    rb = 8'h00;
    dv = 1'b0;
    thr = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) thr = (c / 200 % 3 == 0) ? 10 : ((c / 200 % 3 == 1) ? 50 : 90);
      if (!dv) rb = 8'($urandom);
      dv = ($urandom_range(0, 99) < 50);
      step(dv, rb, ($urandom_range(0, 99) < thr), ($urandom_range(0, 99) < 5), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
